mult_arb: RTL and testbench
===========================

MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles in WAIT before abort (used only with MULT_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  requester 0/1 asks for a multiply; held until grant.
REQ-005 SHALL have ports da0, db0, da1, db1  input  4 each  requester operands; valid while req high.
REQ-006 SHALL have ports gnt0, gnt1  output  1 each  one-cycle accept pulse to the winning requester.
REQ-007 SHALL have ports done0, done1  output  1 each  one-cycle result-valid pulse to the served requester.
REQ-008 SHALL have port p_out  output  8  product of the last served job; held until the next capture.
REQ-009 SHALL have port err  output  1  one-cycle pulse with done_x when the job aborted.
REQ-010 SHALL have port m_start  output  1  one-cycle start pulse to the sequential multiplier.
REQ-011 SHALL have ports m_da, m_db  output  4 each  latched operands to the multiplier; stable from m_start until done_x.
REQ-012 SHALL have port m_done  input  1  multiplier finished; m_p valid in the same cycle.
REQ-013 SHALL have port m_p  input  8  multiplier product.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, RESP, all registered.
REQ-015 IDLE: if req0 or req1 is sampled high, SHALL pick a winner, latch its operands into m_da/m_db and go to ISSUE; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a 1-bit pointer selects the preferred requester on a tie; after each RESP it points to the requester not just served.
REQ-017 ISSUE: SHALL assert m_start and gnt_x of the winner for exactly that one cycle, then go to WAIT.
REQ-018 WAIT: on m_done=1, SHALL capture m_p into p_out and go to RESP; m_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-019 RESP: SHALL assert done_x of the served requester for one cycle, update the pointer and return to IDLE.
REQ-020 Latency: req sampled in IDLE at cycle N gives gnt_x/m_start at N+1; m_done at cycle M gives done_x at M+1 with p_out already valid.
REQ-021 A req dropped before its grant SHALL be a withdrawal, with no side effects.
REQ-022 A req still high in the IDLE cycle after RESP SHALL count as a new request.
REQ-023 With both requests held continuously, grants SHALL alternate 0,1,0,1...
REQ-024 Changes on da_x/db_x after the grant SHALL NOT affect m_da, m_db or the product.
REQ-025 At most one job SHALL be in flight; gnt0 and gnt1, and done0 and done1, SHALL never be high together.

Reset
REQ-026 On reset=0 at a clock edge: state IDLE, pointer=0 (req0 preferred), timeout counter 0.
REQ-027 On reset=0 at a clock edge: gnt0, gnt1, done0, done1, err and m_start SHALL be 0; p_out, m_da and m_db SHALL be 8'h00/4'h0.
REQ-028 Reset in any state, including WAIT, SHALL abandon the job with no done_x; a later m_done SHALL be ignored.

Configuration
REQ-029 With macro MULT_ARB_TIMEOUT_EN defined: a 4-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without m_done.
REQ-030 With MULT_ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT without m_done, SHALL go to RESP with p_out=8'h00 and err=1 alongside done_x.
REQ-031 Without MULT_ARB_TIMEOUT_EN: no counter; WAIT SHALL hold until m_done; err SHALL be tied 0; the port list is unchanged.

Verification
(Bench multiplier model: m_done 9 cycles after m_start, m_p = m_da*m_db.)
REQ-032 After reset, req0 with da0=3, db0=5 -> gnt0 at N+1, m_start with m_da=3, m_db=5, done0 10 cycles later with p_out=8'd15.
REQ-033 req0 (15x15) and req1 (2x7) both high from reset -> job 0 first with p_out=225 and done0, then gnt1 in the cycle after IDLE, p_out=14 and done1.
REQ-034 Both reqs held for 4 jobs -> grant order 0,1,0,1; gnt and done never both high together.
REQ-035 reset=0 for one cycle during WAIT of a 4x4 job -> no done_x, all outputs 0, the late m_done is ignored, and the next req0 (1x9) gives p_out=9.
REQ-036 With MULT_ARB_TIMEOUT_EN and TIMEOUT=15, the model never asserts m_done -> done_x and err together 16 cycles after m_start, p_out=0, and the next job runs normally.
REQ-037 da0 changed from 6 to 1 one cycle after gnt0 (db0=6) -> p_out=36.

Source files
------------

// File: rtl/mult_arb.sv
// Round-robin front end sharing one sequential 4x4 multiplier between two requesters.
// Define MULT_ARB_TIMEOUT_EN to abort jobs the multiplier does not finish within TIMEOUT WAIT cycles.
module mult_arb #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] da0,
    input  logic [3:0] db0,
    input  logic [3:0] da1,
    input  logic [3:0] db1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] p_out,
    output logic       err,
    output logic       m_start,
    output logic [3:0] m_da,
    output logic [3:0] m_db,
    input  logic       m_done,
    input  logic [7:0] m_p
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_ptr;
    logic       r_win;
    logic       w_win;
    logic       w_any;
    logic       w_to_hit;
    logic [3:0] r_da;
    logic [3:0] r_db;
    logic [7:0] r_p;

    // On a tie the pointer decides; otherwise whoever is asking wins.
    assign w_any = req0 | req1;
    assign w_win = (req0 && req1) ? r_ptr : req1;

    assign p_out = r_p;
    assign m_da  = r_da;
    assign m_db  = r_db;

    always_comb begin
        w_next  = r_state;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        m_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_next = ISSUE;
            end
            ISSUE: begin
                m_start = 1'b1;
                gnt0    = ~r_win;
                gnt1    = r_win;
                w_next  = WAIT;
            end
            WAIT: begin
                if (m_done || w_to_hit) w_next = RESP;
            end
            RESP: begin
                done0  = ~r_win;
                done1  = r_win;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_win   <= 1'b0;
            r_da    <= 4'h0;
            r_db    <= 4'h0;
            r_p     <= 8'h00;
        end else begin
            r_state <= w_next;
            // Operands are frozen here so later changes on da_x/db_x cannot reach the job.
            if (r_state == IDLE && w_any) begin
                r_win <= w_win;
                r_da  <= w_win ? da1 : da0;
                r_db  <= w_win ? db1 : db0;
            end
            if (r_state == WAIT && m_done) begin
                r_p <= m_p;
            end else if (w_to_hit) begin
                r_p <= 8'h00;
            end
            if (r_state == RESP) r_ptr <= ~r_win;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    logic [3:0] r_cnt;
    logic       r_err;

    // Abort on the WAIT cycle whose increment would bring the count to TIMEOUT.
    assign w_to_hit = (r_state == WAIT) && !m_done && (r_cnt == CNT_LAST);
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 4'h0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_to_hit;
            if (r_state == ISSUE) begin
                r_cnt <= 4'h0;
            end else if (r_state == WAIT && !m_done) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign err      = 1'b0;

    // TIMEOUT has no effect without the abort path.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

endmodule

// File: tb/tb_mult_arb.sv
// Self-checking bench for mult_arb: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with spurious m_done.
`timescale 1ns/1ps
module tb_mult_arb;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] da0 = 4'h0, db0 = 4'h0, da1 = 4'h0, db1 = 4'h0;
    logic       m_done = 1'b0;
    logic [7:0] m_p = 8'h00;
    logic       gnt0, gnt1, done0, done1, err, m_start;
    logic [7:0] p_out;
    logic [3:0] m_da, m_db;

    mult_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .da0(da0), .db0(db0), .da1(da1), .db1(db1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .p_out(p_out), .err(err), .m_start(m_start), .m_da(m_da), .m_db(m_db),
        .m_done(m_done), .m_p(m_p)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Inputs and multiplier-side outputs as seen during the current cycle.
    logic       s_rst = 1'b0, s_r0 = 1'b0, s_r1 = 1'b0, s_md = 1'b0, s_ms = 1'b0;
    logic [3:0] s_a0 = 4'h0, s_b0 = 4'h0, s_a1 = 4'h0, s_b1 = 4'h0, s_mda = 4'h0, s_mdb = 4'h0;
    logic [7:0] s_mp = 8'h00;

    // Reference model: one job record plus the round-robin pointer.
    bit         busy = 1'b0;
    bit         win = 1'b0;
    bit         ptr = 1'b0;
    bit         timed = 1'b0;
    int         issue_c = -1;
    int         done_c = -1;
    int         waited = 0;
    logic [7:0] e_p = 8'h00;
    logic [3:0] e_a = 4'h0, e_b = 4'h0;

    // Multiplier model.
    bit         mult_en = 1'b1;
    bit         spur_en = 1'b0;
    int         lat = 9;
    int         due = -1;
    logic [7:0] prod = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit ge, de;
        s_rst = reset; s_r0 = req0; s_r1 = req1;
        s_a0 = da0; s_b0 = db0; s_a1 = da1; s_b1 = db1;
        s_md = m_done; s_mp = m_p; s_ms = m_start; s_mda = m_da; s_mdb = m_db;
        ge = busy && (cyc == issue_c);
        de = busy && (cyc == done_c);
        check("gnt0", gnt0, ge && !win);
        check("gnt1", gnt1, ge && win);
        check("m_start", m_start, ge);
        check("done0", done0, de && !win);
        check("done1", done1, de && win);
        check("err", err, de && timed);
        check("p_out", p_out, e_p);
        check("m_da", m_da, e_a);
        check("m_db", m_db, e_b);
    end

    always @(posedge clk) begin
        int c;
        bit rd;
        c = cyc;
        if (!s_rst) begin
            busy = 1'b0; ptr = 1'b0; timed = 1'b0;
            issue_c = -1; done_c = -1;
            e_p = 8'h00; e_a = 4'h0; e_b = 4'h0;
        end else if (!busy) begin
            if (s_r0 || s_r1) begin
                win = (s_r0 && s_r1) ? ptr : s_r1;
                e_a = win ? s_a1 : s_a0;
                e_b = win ? s_b1 : s_b0;
                busy = 1'b1; issue_c = c + 1; done_c = -1; waited = 0; timed = 1'b0;
            end
        end else if (c == done_c) begin
            busy = 1'b0;
            ptr = !win;
        end else if (c > issue_c && done_c < 0) begin
            if (s_md) begin
                done_c = c + 1;
                e_p = s_mp;
            end else begin
`ifdef MULT_ARB_TIMEOUT_EN
                waited++;
                if (waited == TIMEOUT) begin
                    done_c = c + 1;
                    e_p = 8'h00;
                    timed = 1'b1;
                end
`endif
            end
        end
        if (s_ms) begin
            due = c + lat;
            prod = 8'(s_mda) * 8'(s_mdb);
        end
        cyc = c + 1;
        #1;
        rd = mult_en && (cyc == due);
        m_done = rd || (spur_en && ($urandom_range(0, 15) == 0));
        m_p = rd ? prod : 8'($urandom);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int w);
        case (w)
            0: return gnt0;
            1: return gnt1;
            2: return done0;
            3: return done1;
            default: return m_start;
        endcase
    endfunction

    task automatic wait_hi(input string name, input int w, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig_of(w) === 1'b1) begin
                at = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s got=no pulse want=pulse within %0d cycles", name, limit);
    endtask

    task automatic do_reset(input int n);
        next();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (n) next();
        reset = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check({tag, "_gnt"}, {gnt0, gnt1, m_start}, 0);
        check({tag, "_done"}, {done0, done1, err}, 0);
        check({tag, "_p_out"}, p_out, 0);
        check({tag, "_m_da"}, m_da, 0);
        check({tag, "_m_db"}, m_db, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, at2, n;
        int order[4];
        repeat (3) next();
        reset = 1'b1;
        reset_checks("rst0");

        // 3x5 from idle: grant one cycle after the request, done ten after m_start.
        do_reset(2);
        reset_checks("rst1");
        next();
        req0 = 1'b1; da0 = 4'd3; db0 = 4'd5; t0 = cyc;
        wait_hi("032_gnt0", 0, 5, at);
        check("032_gnt_lat", at - t0, 1);
        check("032_m_start", m_start, 1);
        check("032_m_da", m_da, 3);
        check("032_m_db", m_db, 5);
        next();
        req0 = 1'b0; da0 = 4'd9;
        wait_hi("032_done0", 2, 20, at2);
        check("032_done_lat", at2 - at, 10);
        check("032_p_out", p_out, 15);

        // Both asking out of reset: job 0 first, job 1 granted two cycles after done0.
        next();
        reset = 1'b0; req0 = 1'b1; da0 = 4'd15; db0 = 4'd15; req1 = 1'b1; da1 = 4'd2; db1 = 4'd7;
        next();
        reset = 1'b1;
        wait_hi("033_gnt0", 0, 5, at);
        next();
        req0 = 1'b0;
        wait_hi("033_done0", 2, 20, at);
        check("033_p0", p_out, 225);
        wait_hi("033_gnt1", 1, 5, at2);
        check("033_gnt1_gap", at2 - at, 2);
        check("033_m_da", m_da, 2);
        next();
        req1 = 1'b0;
        wait_hi("033_done1", 3, 20, at);
        check("033_p1", p_out, 14);

        // Both held continuously: grants must alternate starting with requester 0.
        do_reset(1);
        next();
        req0 = 1'b1; req1 = 1'b1; da0 = 4'd7; db0 = 4'd3; da1 = 4'd11; db1 = 4'd4;
        for (int j = 0; j < 4; j++) begin
            wait_hi("034_grant", 4, 30, at);
            order[j] = int'(gnt1);
        end
        check("034_order0", order[0], 0);
        check("034_order1", order[1], 1);
        check("034_order2", order[2], 0);
        check("034_order3", order[3], 1);
        next();
        req0 = 1'b0; req1 = 1'b0;
        repeat (15) next();

        // Operand change right after the grant must not reach the product.
        req0 = 1'b1; da0 = 4'd6; db0 = 4'd6;
        wait_hi("037_gnt0", 0, 5, at);
        next();
        da0 = 4'd1; req0 = 1'b0;
        wait_hi("037_done0", 2, 20, at);
        check("037_p_out", p_out, 36);

        // Reset in the middle of WAIT abandons the job; its late m_done is ignored.
        next();
        req0 = 1'b1; da0 = 4'd4; db0 = 4'd4;
        wait_hi("035_gnt0", 0, 5, at);
        next();
        req0 = 1'b0;
        repeat (3) next();
        reset = 1'b0;
        next();
        reset = 1'b1;
        reset_checks("035_rst");
        n = 0;
        repeat (12) begin
            @(negedge clk);
            n += int'(done0 | done1);
        end
        check("035_no_done", n, 0);
        next();
        req0 = 1'b1; da0 = 4'd1; db0 = 4'd9;
        wait_hi("035_gnt0b", 0, 5, at);
        next();
        req0 = 1'b0;
        wait_hi("035_done0", 2, 20, at);
        check("035_p_out", p_out, 9);

`ifdef MULT_ARB_TIMEOUT_EN
        // Silent multiplier: abort sixteen cycles after m_start, then recover.
        next();
        mult_en = 1'b0;
        req0 = 1'b1; da0 = 4'd2; db0 = 4'd3;
        wait_hi("036_gnt0", 0, 5, at);
        next();
        req0 = 1'b0;
        wait_hi("036_done0", 2, 30, at2);
        check("036_abort_lat", at2 - at, 16);
        check("036_err", err, 1);
        check("036_p_out", p_out, 0);
        next();
        mult_en = 1'b1;
        req1 = 1'b1; da1 = 4'd5; db1 = 4'd3;
        wait_hi("036_gnt1", 1, 5, at);
        next();
        req1 = 1'b0;
        wait_hi("036_done1", 3, 20, at);
        check("036_p_after", p_out, 15);
        check("036_err_after", err, 0);
`endif

        // Random traffic: withdrawals, operand churn, variable latency, stray m_done, rare resets.
        spur_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            next();
            reset = ($urandom_range(0, 59) != 0);
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            da0 = 4'($urandom); db0 = 4'($urandom);
            da1 = 4'($urandom); db1 = 4'($urandom);
            lat = $urandom_range(1, 12);
        end
        next();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; spur_en = 1'b0; lat = 9;
        repeat (20) next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
